vga_sync_decoder: RTL and testbench

Receive-side counterpart of `vga_driver`. It samples the `hsync`/`vsync`/`rgb` stream the driver emits, recovers pixel coordinates and a pixel-valid strobe, and checks line and frame timing against the 640x480 mode parameters. It sits in the PPU simulation/self-check path on the VGA clock domain, after `vga_driver` outputs, and feeds scoreboards or a frame-capture buffer.

---
 rtl/vga_sync_decoder.sv | 147 ++++++++++++++
 tb/tb_vga_sync_decoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from a VGA hsync/vsync/rgb stream and checks line/frame timing.
// Locks after two clean frame starts; any timing violation drops back to searching.
module vga_sync_decoder #(
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BACK  = 40,
    parameter int unsigned H_LEFT  = 8,
    parameter int unsigned H_VALID = 640,
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 25,
    parameter int unsigned V_TOP   = 8,
    parameter int unsigned V_VALID = 480,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned POS_BIT = 10
) (
    input  logic               vga_clk,
    input  logic               rst,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [11:0]        rgb,
    output logic               pix_valid,
    output logic [POS_BIT-1:0] pix_x,
    output logic [POS_BIT-1:0] pix_y,
    output logic [11:0]        pix_rgb,
    output logic               frame_start,
    output logic               locked,
    output logic               timing_err,
    output logic [7:0]         err_cnt,
    output logic [15:0]        frame_cnt
);

    localparam logic [10:0] HActLo    = 11'(H_SYNC + H_BACK + H_LEFT);
    localparam logic [10:0] HActHi    = 11'(H_SYNC + H_BACK + H_LEFT + H_VALID);
    localparam logic [10:0] HTotal    = 11'(H_TOTAL);
    localparam logic [10:0] HLast     = 11'(H_TOTAL - 1);
    localparam logic [10:0] HSyncLast = 11'(H_SYNC - 1);
    localparam logic [9:0]  VActLo    = 10'(V_SYNC + V_BACK + V_TOP);
    localparam logic [9:0]  VActHi    = 10'(V_SYNC + V_BACK + V_TOP + V_VALID);
    localparam logic [9:0]  VTotal    = 10'(V_TOTAL);
    localparam logic [9:0]  VLast     = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {StSearch, StTrack, StLocked} state_e;

    state_e state_q, state_d;

    logic              hs_q, vs_q, hs_prev_q, vs_hedge_q, vs_hedge_d;
    logic [11:0]       rgb_q;
    logic [10:0]       h_cnt_q, h_cnt_d;
    logic [9:0]        v_cnt_q, v_cnt_d;
    logic              hs_rise, hs_fall, fs, viol, active;
    logic              e1, e2, e3, e4, e5;

    logic               pix_valid_q, frame_start_q, locked_q, timing_err_q;
    logic [POS_BIT-1:0] pix_x_q, pix_y_q, pix_x_d, pix_y_d;
    logic [11:0]        pix_rgb_q;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    always_comb begin
        hs_rise = hs_q & ~hs_prev_q;
        hs_fall = ~hs_q & hs_prev_q;
        h_cnt_d = hs_rise ? 11'd0 : ((&h_cnt_q) ? h_cnt_q : h_cnt_q + 11'd1);

        // Frame start: vsync seen high at this hsync edge but low at the previous one
        fs         = hs_rise & vs_q & ~vs_hedge_q;
        vs_hedge_d = hs_rise ? vs_q : vs_hedge_q;
        v_cnt_d    = v_cnt_q;
        if (hs_rise) begin
            v_cnt_d = fs ? 10'd0 : ((&v_cnt_q) ? v_cnt_q : v_cnt_q + 10'd1);
        end

        e1   = hs_rise & (h_cnt_q != HLast);
        e2   = hs_fall & (h_cnt_q != HSyncLast);
        e3   = ~hs_rise & (h_cnt_d == HTotal);
        e4   = fs & (v_cnt_q != VLast);
        e5   = hs_rise & ~fs & (v_cnt_d == VTotal);
        viol = (e1 | e2 | e3 | e4 | e5) & (state_q != StSearch);

        state_d = state_q;
        unique case (state_q)
            StSearch: if (fs) state_d = StTrack;
            StTrack:  if (viol) state_d = StSearch;
                      else if (fs) state_d = StLocked;
            StLocked: if (viol) state_d = StSearch;
            default:  state_d = StSearch;
        endcase

        active = (h_cnt_d >= HActLo) && (h_cnt_d < HActHi) &&
                 (v_cnt_d >= VActLo) && (v_cnt_d < VActHi);
        pix_x_d = active ? POS_BIT'(h_cnt_d - HActLo) : '0;
        pix_y_d = active ? POS_BIT'(v_cnt_d - VActLo) : '0;

        err_cnt_d   = (viol && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
        frame_cnt_d = (fs && (state_d == StLocked)) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            rgb_q         <= '0;
            hs_prev_q     <= 1'b0;
            vs_hedge_q    <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            state_q       <= StSearch;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            timing_err_q  <= 1'b0;
            err_cnt_q     <= '0;
            frame_cnt_q   <= '0;
        end else begin
            hs_q          <= hsync;
            vs_q          <= vsync;
            rgb_q         <= rgb;
            hs_prev_q     <= hs_q;
            vs_hedge_q    <= vs_hedge_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            state_q       <= state_d;
            pix_valid_q   <= active & (state_d == StLocked);
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= rgb_q;
            frame_start_q <= fs & (state_q != StSearch);
            locked_q      <= (state_d == StLocked);
            timing_err_q  <= viol;
            err_cnt_q     <= err_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign timing_err  = timing_err_q;
    assign err_cnt     = err_cnt_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down 20x12 timing mode.
module tb_vga_sync_decoder;

    localparam int HS = 4, HB = 2, HL = 1, HV = 8, HT = 20;
    localparam int VS = 2, VB = 1, VTP = 1, VV = 6, VT = 12;
    localparam int HA = HS + HB + HL;  // 7
    localparam int VA = VS + VB + VTP; // 4

    logic        clk = 1'b0;
    logic        rst, hsync, vsync;
    logic [11:0] rgb;
    logic        pix_valid, frame_start, locked, timing_err;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] pix_rgb;
    logic [7:0]  err_cnt;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_SYNC(HS), .H_BACK(HB), .H_LEFT(HL), .H_VALID(HV), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_TOP(VTP), .V_VALID(VV), .V_TOTAL(VT),
        .POS_BIT(10)
    ) dut (
        .vga_clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
        .err_cnt(err_cnt), .frame_cnt(frame_cnt)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] mk_rgb(input int l, input int c);
        logic [31:0] lv, cv;
        lv = l;
        cv = c;
        return {lv[5:0], cv[5:0]};
    endfunction

    function automatic logic [63:0] out_vec();
        return {4'b0, pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, timing_err,
                err_cnt, frame_cnt};
    endfunction

    // Monitor: outputs seen after a posedge describe the sample taken one posedge earlier
    int drv_line = 0, drv_col = 0, tag_line = 0, tag_col = 0;
    int valid_cnt = 0, fs_cnt = 0, terr_cnt = 0, map_bad = 0;
    logic        seen_valid = 1'b0, lock_at_fs = 1'b0;
    logic [9:0]  first_x = '1, first_y = '1;
    logic [11:0] first_rgb = '1;

    always begin
        @(posedge clk);
        #2;
        if (pix_valid) begin
            valid_cnt++;
            if (!seen_valid) begin
                seen_valid = 1'b1;
                first_x    = pix_x;
                first_y    = pix_y;
                first_rgb  = pix_rgb;
            end
            if (int'(pix_x) != tag_col - HA || int'(pix_y) != tag_line - VA ||
                pix_rgb != mk_rgb(tag_line, tag_col)) map_bad++;
        end
        if (frame_start) begin
            if (fs_cnt == 0) lock_at_fs = locked;
            fs_cnt++;
        end
        if (timing_err) terr_cnt++;
        tag_line = drv_line;
        tag_col  = drv_col;
    end

    logic [63:0] rst_snap = '1;

    task automatic send_line(input int l, input int len, input int sw, input logic vs,
                             input int rc);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (rc >= 0 && c == rc + 1) begin
                rst_snap = out_vec();
                rst = 1'b0;
            end
            hsync    = (c < sw);
            vsync    = vs;
            rgb      = mk_rgb(l, c);
            drv_line = l;
            drv_col  = c;
            if (c == rc) rst = 1'b1;
        end
    endtask

    task automatic send_frame(input logic no_vs, input int short_l, input int sync_l,
                              input int rst_l);
        for (int l = 0; l < VT; l++) begin
            send_line(l, (l == short_l) ? HT - 1 : HT, (l == sync_l) ? HS - 1 : HS,
                      !no_vs && (l < VS), (l == rst_l) ? 10 : -1);
        end
    endtask

    initial begin
        int v0, t0;
        rst = 1'b1; hsync = 1'b0; vsync = 1'b0; rgb = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", out_vec(), 64'd0);
        rst = 1'b0;

        // Nominal: three clean frames
        v0 = valid_cnt;
        send_frame(1'b0, -1, -1, -1);
        chk("f1_locked", 64'(locked), 64'd0);
        chk("f1_valid", 64'(valid_cnt - v0), 64'd0);
        v0 = valid_cnt;
        send_frame(1'b0, -1, -1, -1);
        chk("f2_valid", 64'(valid_cnt - v0), 64'd48);
        chk("lock_at_fs2", 64'(lock_at_fs), 64'd1);
        v0 = valid_cnt;
        send_frame(1'b0, -1, -1, -1);
        chk("f3_valid", 64'(valid_cnt - v0), 64'd48);
        chk("fs_pulses", 64'(fs_cnt), 64'd2);
        chk("f3_locked", 64'(locked), 64'd1);
        chk("f3_frame_cnt", 64'(frame_cnt), 64'd2);
        chk("f3_err_cnt", 64'(err_cnt), 64'd0);
        chk("first_x", 64'(first_x), 64'd0);
        chk("first_y", 64'(first_y), 64'd0);
        chk("first_rgb", 64'(first_rgb), 64'h107);

        // Short line in frame 4 (E1), then relock over frames 5 and 6
        t0 = terr_cnt;
        send_frame(1'b0, 1, -1, -1);
        chk("short_err_cnt", 64'(err_cnt), 64'd1);
        chk("short_locked", 64'(locked), 64'd0);
        chk("short_pulses", 64'(terr_cnt - t0), 64'd1);
        send_frame(1'b0, -1, -1, -1);
        chk("short_f5_locked", 64'(locked), 64'd0);
        send_frame(1'b0, -1, -1, -1);
        chk("short_relock", 64'(locked), 64'd1);
        chk("short_frame_cnt", 64'(frame_cnt), 64'd4);

        // Narrow hsync pulse (E2)
        send_frame(1'b0, -1, 3, -1);
        chk("sync_err_cnt", 64'(err_cnt), 64'd2);
        chk("sync_locked", 64'(locked), 64'd0);
        send_frame(1'b0, -1, -1, -1);
        send_frame(1'b0, -1, -1, -1);
        chk("sync_relock", 64'(locked), 64'd1);
        chk("sync_frame_cnt", 64'(frame_cnt), 64'd6);

        // Missing vsync (E5)
        send_frame(1'b0, -1, -1, -1);
        v0 = valid_cnt;
        send_frame(1'b1, -1, -1, -1);
        chk("novs_err_cnt", 64'(err_cnt), 64'd3);
        chk("novs_locked", 64'(locked), 64'd0);
        send_frame(1'b0, -1, -1, -1);
        chk("novs_valid", 64'(valid_cnt - v0), 64'd0);
        chk("novs_f12_locked", 64'(locked), 64'd0);
        send_frame(1'b0, -1, -1, -1);
        chk("novs_relock", 64'(locked), 64'd1);
        chk("novs_frame_cnt", 64'(frame_cnt), 64'd8);

        // Reset pulse mid-frame
        send_frame(1'b0, -1, -1, 5);
        chk("rst_mid_outs", rst_snap, 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        send_frame(1'b0, -1, -1, -1);
        chk("rst_f1_locked", 64'(locked), 64'd0);
        send_frame(1'b0, -1, -1, -1);
        chk("rst_relock", 64'(locked), 64'd1);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd1);

        // 300 violations: each pair re-enters TRACK and then breaks the next line
        t0 = terr_cnt;
        for (int i = 0; i < 300; i++) begin
            send_line(0, HT, HS, 1'b0, -1);
            send_line(0, 10, HS, 1'b1, -1);
        end
        chk("sat_err_cnt", 64'(err_cnt), 64'd255);
        chk("sat_pulses", 64'(terr_cnt - t0), 64'd300);
        chk("sat_locked", 64'(locked), 64'd0);

        chk("pix_map", 64'(map_bad), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
